cart_position_monitor: RTL and testbench
========================================

CART_POSITION_MONITOR -- requirements
Module: cart_position_monitor

Parameters
REQ-001 SHALL provide parameter STALL_LIMIT, default 16, range 1-255: consecutive non-moving valid samples that end a motion state.

Interface
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port POS  input  8  cart position bus; two adjacent ones; MSB end = left, LSB end = right.
REQ-005 SHALL have port CLR  input  1  synchronous clear of counters, fault and state.
REQ-006 SHALL have port IDX  output  3  decoded cart index 0 (1100_0000) to 6 (0000_0011); 7 = invalid.
REQ-007 SHALL have port VALID  output  1  last sample was a legal pattern.
REQ-008 SHALL have port MOVE_R / MOVE_L  output  1 each  single-cycle step pulses.
REQ-009 SHALL have port STEPS  output  8  saturating total step count.
REQ-010 SHALL have port REVERSALS  output  4  saturating direction-reversal count.
REQ-011 SHALL have port AT_LEFT / AT_RIGHT  output  1 each  cart at index 0 / index 6.
REQ-012 SHALL have port FAULT  output  1  sticky error flag.
REQ-013 SHALL have port STATE  output  2  IDLE=0, RIGHT=1, LEFT=2, FAULT=3.

Function
REQ-014 SHALL sample POS every rising edge; all outputs SHALL be registered and reflect the sample taken on that edge (latency 1 cycle).
REQ-015 SHALL decode index k for POS = 8'b1100_0000 >> k, k = 0..6; any other pattern SHALL give IDX=7, VALID=0, AT_LEFT=0, AT_RIGHT=0.
REQ-016 SHALL hold last_idx, the index of the last valid sample; invalid samples SHALL NOT update it.
REQ-017 Valid sample with idx = last_idx+1 SHALL pulse MOVE_R for 1 cycle; idx = last_idx-1 SHALL pulse MOVE_L; idx = last_idx SHALL pulse neither.
REQ-018 Valid sample with |idx - last_idx| > 1, or any invalid sample, SHALL set FAULT and enter FAULT.
REQ-019 Each MOVE pulse SHALL increment STEPS, saturating at 255.
REQ-020 SHALL transition IDLE->RIGHT on MOVE_R, IDLE->LEFT on MOVE_L.
REQ-021 SHALL transition RIGHT->LEFT on MOVE_L and LEFT->RIGHT on MOVE_R, each incrementing REVERSALS, saturating at 15.
REQ-022 In RIGHT/LEFT, a stall counter SHALL count consecutive valid non-moving samples, clear on any move, and return to IDLE when it reaches STALL_LIMIT.
REQ-023 In FAULT, decode outputs (IDX, VALID, AT_*) SHALL keep tracking POS; MOVE pulses SHALL be suppressed; STEPS/REVERSALS SHALL freeze; exit only via CLR or RESET.
REQ-024 CLR SHALL take priority over all events on the same edge: STEPS=0, REVERSALS=0, FAULT=0, stall count 0, STATE=IDLE, no MOVE pulse.
REQ-025 On a CLR edge, decode outputs SHALL update normally and last_idx SHALL load the sampled index if valid, else stay unchanged.

Reset
REQ-026 RESET SHALL immediately force IDX=0, VALID=1, AT_LEFT=1, AT_RIGHT=0, MOVE_R=MOVE_L=0, STEPS=0, REVERSALS=0, FAULT=0, STATE=IDLE, last_idx=0, stall count 0, matching cart home position 1100_0000.
REQ-027 RESET asserted mid-motion or in FAULT SHALL abandon all state; first edge after release SHALL compare against last_idx=0.

Verification
REQ-028 Reset, POS=1100_0000 held 5 cycles -> IDX=0, VALID=1, AT_LEFT=1, STATE=0, STEPS=0, no MOVE pulses.
REQ-029 POS shifted right once per cycle to 0000_0011 -> six 1-cycle MOVE_R pulses, STEPS=6, IDX=6, AT_RIGHT=1, STATE=1.
REQ-030 Continue with two left shifts to 0000_1100 -> two MOVE_L pulses, REVERSALS=1, STEPS=8, IDX=4, STATE=2.
REQ-031 From IDX=0 apply POS=0001_1000 (jump to 3) -> FAULT=1, STATE=3, IDX=3, no MOVE pulse; then POS=1010_0000 -> VALID=0, IDX=7; CLR -> FAULT=0, STATE=0, STEPS=0.
REQ-032 One MOVE_R then POS held, STALL_LIMIT=16 -> STATE=1 through 15 held samples, STATE=0 after 16th.
REQ-033 RESET pulsed while STATE=1 with STEPS=5 -> all outputs at REQ-026 values immediately, before next CLK edge.

Source files
------------

// File: rtl/cart_position_monitor.sv
// rtl/cart_position_monitor.sv - two-bit cart position decoder with step, reversal, stall and fault tracking
module cart_position_monitor #(
    parameter int STALL_LIMIT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] POS,
    input  logic       CLR,
    output logic [2:0] IDX,
    output logic       VALID,
    output logic       MOVE_R,
    output logic       MOVE_L,
    output logic [7:0] STEPS,
    output logic [3:0] REVERSALS,
    output logic       AT_LEFT,
    output logic       AT_RIGHT,
    output logic       FAULT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RIGHT = 2'd1,
        ST_LEFT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t     state_q;
    logic [2:0] last_idx;
    logic [7:0] stall_cnt;
    logic [7:0] stall_next;
    logic [2:0] dec_idx;
    logic       dec_valid;
    logic       step_r;
    logic       step_l;
    logic       hold;

    assign STATE      = state_q;
    assign stall_next = stall_cnt + 8'd1;

    // Decode the cart pattern and classify it against the last legal index
    always_comb begin
        dec_idx   = 3'd7;
        dec_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (POS == (8'hC0 >> k)) begin
                dec_idx   = 3'(k);
                dec_valid = 1'b1;
            end
        end
        // Widened to 4 bits so index 6/7 arithmetic cannot wrap
        step_r = dec_valid && ({1'b0, dec_idx} == ({1'b0, last_idx} + 4'd1));
        step_l = dec_valid && (({1'b0, dec_idx} + 4'd1) == {1'b0, last_idx});
        hold   = dec_valid && (dec_idx == last_idx);
    end

    // Registered decode, motion tracking and state machine
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            IDX       <= 3'd0;
            VALID     <= 1'b1;
            AT_LEFT   <= 1'b1;
            AT_RIGHT  <= 1'b0;
            MOVE_R    <= 1'b0;
            MOVE_L    <= 1'b0;
            STEPS     <= 8'd0;
            REVERSALS <= 4'd0;
            FAULT     <= 1'b0;
            state_q   <= ST_IDLE;
            last_idx  <= 3'd0;
            stall_cnt <= 8'd0;
        end else begin
            IDX      <= dec_idx;
            VALID    <= dec_valid;
            AT_LEFT  <= dec_valid && (dec_idx == 3'd0);
            AT_RIGHT <= dec_valid && (dec_idx == 3'd6);
            MOVE_R   <= 1'b0;
            MOVE_L   <= 1'b0;
            if (dec_valid) begin
                last_idx <= dec_idx;
            end

            if (CLR) begin
                STEPS     <= 8'd0;
                REVERSALS <= 4'd0;
                FAULT     <= 1'b0;
                stall_cnt <= 8'd0;
                state_q   <= ST_IDLE;
            end else if (state_q == ST_FAULT) begin
                // Counters and pulses stay frozen until CLR or RESET
            end else if (!(step_r || step_l || hold)) begin
                FAULT     <= 1'b1;
                state_q   <= ST_FAULT;
                stall_cnt <= 8'd0;
            end else if (step_r || step_l) begin
                MOVE_R    <= step_r;
                MOVE_L    <= step_l;
                stall_cnt <= 8'd0;
                if (STEPS != 8'hFF) begin
                    STEPS <= STEPS + 8'd1;
                end
                case (state_q)
                    ST_IDLE:  state_q <= step_r ? ST_RIGHT : ST_LEFT;
                    ST_RIGHT: if (step_l) begin
                        state_q <= ST_LEFT;
                        if (REVERSALS != 4'hF) REVERSALS <= REVERSALS + 4'd1;
                    end
                    ST_LEFT:  if (step_r) begin
                        state_q <= ST_RIGHT;
                        if (REVERSALS != 4'hF) REVERSALS <= REVERSALS + 4'd1;
                    end
                    default:  state_q <= ST_FAULT;
                endcase
            end else if (state_q == ST_RIGHT || state_q == ST_LEFT) begin
                if (stall_next >= 8'(STALL_LIMIT)) begin
                    state_q   <= ST_IDLE;
                    stall_cnt <= 8'd0;
                end else begin
                    stall_cnt <= stall_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_cart_position_monitor.sv
// tb/tb_cart_position_monitor.sv - scoreboard bench for cart_position_monitor
module tb_cart_position_monitor;

    localparam int LIMIT = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] POS;
    logic       CLR;
    logic [2:0] IDX;
    logic       VALID;
    logic       MOVE_R;
    logic       MOVE_L;
    logic [7:0] STEPS;
    logic [3:0] REVERSALS;
    logic       AT_LEFT;
    logic       AT_RIGHT;
    logic       FAULT;
    logic [1:0] STATE;

    typedef struct packed {
        logic [2:0] idx;
        logic       valid;
        logic       mr;
        logic       ml;
        logic [7:0] steps;
        logic [3:0] rev;
        logic       atl;
        logic       atr;
        logic       fault;
        logic [1:0] state;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    int m_last, m_steps, m_rev, m_stall, m_state, m_fault;

    cart_position_monitor #(.STALL_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET), .POS(POS), .CLR(CLR),
        .IDX(IDX), .VALID(VALID), .MOVE_R(MOVE_R), .MOVE_L(MOVE_L),
        .STEPS(STEPS), .REVERSALS(REVERSALS), .AT_LEFT(AT_LEFT),
        .AT_RIGHT(AT_RIGHT), .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(output exp_t e);
        m_last = 0; m_steps = 0; m_rev = 0; m_stall = 0; m_state = 0; m_fault = 0;
        e = '{idx: 3'd0, valid: 1'b1, mr: 1'b0, ml: 1'b0, steps: 8'd0, rev: 4'd0,
              atl: 1'b1, atr: 1'b0, fault: 1'b0, state: 2'd0};
    endtask

    // Reference behaviour of one sampled edge
    task automatic model_step(input logic [7:0] p, input logic c, output exp_t e);
        int idx, diff;
        bit valid, mr, ml;
        logic [7:0] pat;
        idx = 7; valid = 0; mr = 0; ml = 0;
        for (int k = 0; k < 7; k++) begin
            pat = 8'hC0 >> k;
            if (p == pat) begin idx = k; valid = 1; end
        end
        if (c) begin
            m_steps = 0; m_rev = 0; m_fault = 0; m_stall = 0; m_state = 0;
            if (valid) m_last = idx;
        end else if (m_state == 3) begin
            if (valid) m_last = idx;
        end else if (!valid) begin
            m_fault = 1; m_state = 3; m_stall = 0;
        end else begin
            diff = idx - m_last;
            m_last = idx;
            if (diff == 1) mr = 1;
            else if (diff == -1) ml = 1;
            else if (diff != 0) begin m_fault = 1; m_state = 3; m_stall = 0; end
            if (mr || ml) begin
                m_stall = 0;
                if (m_steps < 255) m_steps++;
                if ((m_state == 1 && ml) || (m_state == 2 && mr))
                    if (m_rev < 15) m_rev++;
                m_state = mr ? 1 : 2;
            end else if (diff == 0 && (m_state == 1 || m_state == 2)) begin
                m_stall++;
                if (m_stall == LIMIT) begin m_state = 0; m_stall = 0; end
            end
        end
        e.idx = 3'(idx); e.valid = valid; e.mr = mr; e.ml = ml;
        e.steps = 8'(m_steps); e.rev = 4'(m_rev);
        e.atl = valid && idx == 0; e.atr = valid && idx == 6;
        e.fault = 1'(m_fault); e.state = 2'(m_state);
    endtask

    task automatic compare(input exp_t e, input string tag);
        chk({tag, ".idx"},   9'(IDX),       9'(e.idx));
        chk({tag, ".valid"}, 9'(VALID),     9'(e.valid));
        chk({tag, ".mr"},    9'(MOVE_R),    9'(e.mr));
        chk({tag, ".ml"},    9'(MOVE_L),    9'(e.ml));
        chk({tag, ".steps"}, 9'(STEPS),     9'(e.steps));
        chk({tag, ".rev"},   9'(REVERSALS), 9'(e.rev));
        chk({tag, ".atl"},   9'(AT_LEFT),   9'(e.atl));
        chk({tag, ".atr"},   9'(AT_RIGHT),  9'(e.atr));
        chk({tag, ".fault"}, 9'(FAULT),     9'(e.fault));
        chk({tag, ".state"}, 9'(STATE),     9'(e.state));
    endtask

    // Drive one sample, push its expectation, then pop and compare after the edge
    task automatic step(input logic [7:0] p, input logic c, input string tag);
        exp_t e;
        POS = p; CLR = c;
        model_step(p, c, e);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        chk({tag, ".sb_pending"}, 9'(sb_q.size()), 9'd1);
        if (sb_q.size() != 0) compare(sb_q.pop_front(), tag);
        CLR = 1'b0;
    endtask

    initial begin
        exp_t e;
        RESET = 1'b1; POS = 8'hC0; CLR = 1'b0;
        #3;
        model_reset(e);
        compare(e, "reset");
        #4 RESET = 1'b0;

        // Home position held
        for (int i = 0; i < 5; i++) step(8'hC0, 1'b0, "home");

        // Six right shifts to the right end
        for (int k = 1; k <= 6; k++) step(8'hC0 >> k, 1'b0, "right");
        chk("right.steps_const", 9'(STEPS), 9'd6);
        chk("right.idx_const", 9'(IDX), 9'd6);
        chk("right.atr_const", 9'(AT_RIGHT), 9'd1);
        chk("right.state_const", 9'(STATE), 9'd1);

        // Two left shifts: one reversal
        step(8'h06, 1'b0, "left");
        step(8'h0C, 1'b0, "left");
        chk("left.rev_const", 9'(REVERSALS), 9'd1);
        chk("left.steps_const", 9'(STEPS), 9'd8);
        chk("left.idx_const", 9'(IDX), 9'd4);
        chk("left.state_const", 9'(STATE), 9'd2);

        // Back to index 0 via CLR, then a jump fault
        step(8'hC0, 1'b1, "clr_home");
        step(8'h18, 1'b0, "jump");
        chk("jump.fault_const", 9'(FAULT), 9'd1);
        chk("jump.state_const", 9'(STATE), 9'd3);
        chk("jump.idx_const", 9'(IDX), 9'd3);
        chk("jump.mr_const", 9'(MOVE_R), 9'd0);
        step(8'hA0, 1'b0, "bad_pat");
        chk("bad.valid_const", 9'(VALID), 9'd0);
        chk("bad.idx_const", 9'(IDX), 9'd7);
        step(8'h30, 1'b0, "fault_move");
        step(8'h18, 1'b0, "fault_move");
        step(8'hFF, 1'b1, "clr_invalid");
        chk("clr.fault_const", 9'(FAULT), 9'd0);
        chk("clr.state_const", 9'(STATE), 9'd0);
        chk("clr.steps_const", 9'(STEPS), 9'd0);
        step(8'h30, 1'b0, "after_clr");

        // Stall timeout from RIGHT back to IDLE
        step(8'h18, 1'b0, "stall_go");
        for (int i = 1; i <= LIMIT; i++) begin
            step(8'h18, 1'b0, "stall");
            chk("stall.state_const", 9'(STATE), (i < LIMIT) ? 9'd1 : 9'd0);
        end

        // CLR wins over a move on the same edge
        step(8'h0C, 1'b1, "clr_vs_move");
        chk("clrmove.mr_const", 9'(MOVE_R), 9'd0);

        // Saturation of STEPS and REVERSALS by oscillating
        step(8'hC0, 1'b1, "sat_clr");
        for (int i = 0; i < 260; i++) step((i % 2 == 0) ? 8'h60 : 8'hC0, 1'b0, "osc");
        chk("sat.steps_const", 9'(STEPS), 9'd255);
        chk("sat.rev_const", 9'(REVERSALS), 9'd15);

        // Asynchronous reset mid-motion
        step(8'hC0, 1'b1, "pre_rst");
        for (int k = 1; k <= 5; k++) step(8'hC0 >> k, 1'b0, "pre_rst_move");
        chk("pre_rst.steps_const", 9'(STEPS), 9'd5);
        chk("pre_rst.state_const", 9'(STATE), 9'd1);
        #2 RESET = 1'b1;
        #1;
        model_reset(e);
        compare(e, "async_rst");
        #3 RESET = 1'b0;
        step(8'h60, 1'b0, "post_rst");
        chk("post_rst.mr_const", 9'(MOVE_R), 9'd1);

        // Reset while faulted, then home position
        step(8'h03, 1'b0, "fault_again");
        #2 RESET = 1'b1;
        #1;
        model_reset(e);
        compare(e, "fault_rst");
        #3 RESET = 1'b0;
        step(8'hC0, 1'b0, "post_fault_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
